// File: rtl/dmem_access_ctrl_pkg.sv
// rtl/dmem_access_ctrl_pkg.sv - shared types and constants for the data-memory access controller
// Contents: FSM state enumeration, memory geometry constants, latency-counter width,
//           and an address range helper.
package dmem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dmem_state_t;

    // Eight chips of 1024 words each; chip select lives in addr[12:10].
    localparam int DMEM_WORDS   = 8192;
    localparam int CHIP_SEL_MSB = 12;
    localparam int CHIP_SEL_LSB = 10;

    // Wide enough for READ_LAT up to 15.
    localparam int LAT_CNT_BITS = 4;

    // True when every address bit at or above addr_bits is zero.
    function automatic logic addr_in_range(input logic [31:0] addr, input int addr_bits);
        return (addr >> addr_bits) == 32'd0;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// rtl/dmem_access_ctrl_if.sv - request/response and memory-side bundle for dmem_access_ctrl
// Signals: reqValid/reqReady/reqWrite/reqAddr/reqWData (request),
//          respValid/respReady/respData/respErr (response),
//          memAddr/memDataIn/memReadWrite/memDataOut (data memory).
// Modports: master = requester plus memory model, slave = controller.
interface dmem_access_ctrl_if;

    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [31:0] reqAddr;
    logic [31:0] reqWData;

    logic        respValid;
    logic        respReady;
    logic [31:0] respData;
    logic        respErr;

    logic [31:0] memAddr;
    logic [31:0] memDataIn;
    logic        memReadWrite;
    logic [31:0] memDataOut;

    modport master (
        output reqValid, reqWrite, reqAddr, reqWData, respReady, memDataOut,
        input  reqReady, respValid, respData, respErr, memAddr, memDataIn, memReadWrite
    );

    modport slave (
        input  reqValid, reqWrite, reqAddr, reqWData, respReady, memDataOut,
        output reqReady, respValid, respData, respErr, memAddr, memDataIn, memReadWrite
    );

endinterface

// File: rtl/dmem_lat_counter.sv
// rtl/dmem_lat_counter.sv - 4-bit down-counter with load, decrement and zero flag
// Ports: clk, reset (sync, active-high), load/load_val (load takes priority),
//        dec (decrement, saturates at zero), zero (count == 0).
module dmem_lat_counter
    import dmem_access_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [LAT_CNT_BITS-1:0] load_val,
    input  logic                    dec,
    output logic                    zero
);

    logic [LAT_CNT_BITS-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - single-outstanding load/store controller for the eight-chip data memory
// Parameters: READ_LAT (1..15) cycles memAddr is held before read data is sampled,
//             ADDR_BITS word-address span of the memory.
// Ports: clk, reset (sync, active-high), bus (dmem_access_ctrl_if.slave).
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int READ_LAT  = 2,
    parameter int ADDR_BITS = 13
) (
    input  logic              clk,
    input  logic              reset,
    dmem_access_ctrl_if.slave bus
);

    // The counter reaches zero on the last ACCESS cycle, so it is loaded
    // with one less than the number of ACCESS cycles wanted.
    localparam logic [LAT_CNT_BITS-1:0] LOAD_CNT = LAT_CNT_BITS'(READ_LAT - 1);

    dmem_state_t state, state_next;

    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic                    in_range;
    logic                    cnt_load;
    logic [LAT_CNT_BITS-1:0] cnt_load_val;
    logic                    cnt_dec;
    logic                    cnt_zero;

    assign in_range = addr_in_range(bus.reqAddr, ADDR_BITS);

    dmem_lat_counter u_lat_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        cnt_load         = 1'b0;
        cnt_load_val     = '0;
        cnt_dec          = 1'b0;
        bus.reqReady     = 1'b0;
        bus.respValid    = 1'b0;
        bus.memReadWrite = 1'b0;

        case (state)
            IDLE: begin
                bus.reqReady = 1'b1;
                if (bus.reqValid) begin
                    if (in_range) begin
                        state_next   = ACCESS;
                        cnt_load     = 1'b1;
                        // Stores always take one ACCESS cycle.
                        cnt_load_val = bus.reqWrite ? '0 : LOAD_CNT;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            ACCESS: begin
                cnt_dec          = 1'b1;
                bus.memReadWrite = wr_q;
                if (cnt_zero) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                bus.respValid = 1'b1;
                if (bus.respReady) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Address and write data only move on an in-range acceptance, so the
    // memory side sees no activity for out-of-range requests.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && bus.reqValid) begin
                rdata_q <= '0;
                err_q   <= !in_range;
                if (in_range) begin
                    wr_q    <= bus.reqWrite;
                    addr_q  <= bus.reqAddr;
                    wdata_q <= bus.reqWData;
                end
            end
            if (state == ACCESS && cnt_zero && !wr_q) begin
                rdata_q <= bus.memDataOut;
            end
        end
    end

    assign bus.memAddr   = addr_q;
    assign bus.memDataIn = wdata_q;
    assign bus.respData  = rdata_q;
    assign bus.respErr   = err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - self-checking bench for dmem_access_ctrl at READ_LAT 2, 1 and 15
module tb_dmem_access_ctrl;

    localparam int NDUT = 3;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NDUT-1:0]       req_valid, req_write, resp_ready;
    logic [NDUT-1:0][31:0] req_addr, req_wdata;
    logic [NDUT-1:0]       req_ready, resp_valid, resp_err, mem_rw;
    logic [NDUT-1:0][31:0] resp_data, mem_addr, mem_wdata;

    resp_t       sb [$];
    logic [31:0] shadow [NDUT][8192];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic int lat_of(input int sel);
        return (sel == 0) ? 2 : ((sel == 1) ? 1 : 15);
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dmem_access_ctrl_if bus ();
        logic [31:0] mem [0:8191];

        assign bus.reqValid  = req_valid[g];
        assign bus.reqWrite  = req_write[g];
        assign bus.reqAddr   = req_addr[g];
        assign bus.reqWData  = req_wdata[g];
        assign bus.respReady = resp_ready[g];
        assign bus.memDataOut = mem[bus.memAddr[12:0]];

        assign req_ready[g]  = bus.reqReady;
        assign resp_valid[g] = bus.respValid;
        assign resp_data[g]  = bus.respData;
        assign resp_err[g]   = bus.respErr;
        assign mem_addr[g]   = bus.memAddr;
        assign mem_wdata[g]  = bus.memDataIn;
        assign mem_rw[g]     = bus.memReadWrite;

        always @(posedge clk) begin
            if (bus.memReadWrite) mem[bus.memAddr[12:0]] <= bus.memDataIn;
        end

        dmem_access_ctrl #(
            .READ_LAT  (g == 0 ? 2 : (g == 1 ? 1 : 15)),
            .ADDR_BITS (13)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a negedge; returns just after a negedge with the DUT idle.
    task automatic do_txn(input int sel, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold, output time t_acc);
        logic        in_rng;
        int          exp_lat;
        int          n;
        int          wcount;
        logic        seen;
        resp_t       exp_r;
        logic [31:0] prev_maddr;
        logic [31:0] prev_mwdata;

        in_rng     = (addr[31:13] == 19'd0);
        exp_r.err  = !in_rng;
        exp_r.data = (!wr && in_rng) ? shadow[sel][addr[12:0]] : 32'd0;
        exp_lat    = !in_rng ? 1 : (wr ? 2 : lat_of(sel) + 1);
        if (wr && in_rng) shadow[sel][addr[12:0]] = wdata;
        sb.push_back(exp_r);

        prev_maddr  = mem_addr[sel];
        prev_mwdata = mem_wdata[sel];
        chk("req_ready_idle", 32'(req_ready[sel]), 32'd1);

        req_valid[sel]  = 1'b1;
        req_write[sel]  = wr;
        req_addr[sel]   = addr;
        req_wdata[sel]  = wdata;
        resp_ready[sel] = 1'b0;
        @(posedge clk);
        t_acc = $time;
        #1;
        // Scramble the request inputs: the latched copy must be used.
        req_valid[sel]  = 1'b0;
        req_write[sel]  = ~wr;
        req_addr[sel]   = ~addr;
        req_wdata[sel]  = ~wdata;
        resp_ready[sel] = (hold == 0);

        seen   = 1'b0;
        wcount = 0;
        n      = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (resp_valid[sel]) begin
                seen = 1'b1;
            end else begin
                chk("req_ready_busy", 32'(req_ready[sel]), 32'd0);
                if (mem_rw[sel]) begin
                    wcount++;
                    chk("mem_wr_addr", mem_addr[sel], addr);
                    chk("mem_wr_data", mem_wdata[sel], wdata);
                end
                chk("mem_addr_access", mem_addr[sel], in_rng ? addr : prev_maddr);
                chk("mem_wdata_access", mem_wdata[sel], in_rng ? wdata : prev_mwdata);
                @(posedge clk);
            end
        end
        chk("resp_latency", 32'(n), 32'(exp_lat));
        chk("mem_write_cycles", 32'(wcount), (wr && in_rng) ? 32'd1 : 32'd0);

        exp_r = sb.pop_front();
        chk("resp_data", resp_data[sel], exp_r.data);
        chk("resp_err", 32'(resp_err[sel]), 32'(exp_r.err));
        chk("mem_rw_resp", 32'(mem_rw[sel]), 32'd0);

        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid[sel]), 32'd1);
            chk("hold_data", resp_data[sel], exp_r.data);
            chk("hold_err", 32'(resp_err[sel]), 32'(exp_r.err));
            chk("hold_req_ready", 32'(req_ready[sel]), 32'd0);
        end

        resp_ready[sel] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[sel] = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", 32'(req_ready[sel]), 32'd1);
        chk("idle_resp_valid", 32'(resp_valid[sel]), 32'd0);
        chk("idle_mem_addr", mem_addr[sel], in_rng ? addr : prev_maddr);
    endtask

    initial begin
        time         t0, t1;
        int          cnt;
        logic [31:0] a, d;

        reset      = 1'b1;
        req_valid  = '0;
        req_write  = '0;
        resp_ready = '0;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        for (int s = 0; s < NDUT; s++) begin
            chk("rst_req_ready", 32'(req_ready[s]), 32'd1);
            chk("rst_resp_valid", 32'(resp_valid[s]), 32'd0);
            chk("rst_resp_data", resp_data[s], 32'd0);
            chk("rst_resp_err", 32'(resp_err[s]), 32'd0);
            chk("rst_mem_addr", mem_addr[s], 32'd0);
            chk("rst_mem_wdata", mem_wdata[s], 32'd0);
            chk("rst_mem_rw", 32'(mem_rw[s]), 32'd0);
        end

        // Directed cases at READ_LAT = 2.
        do_txn(0, 1'b1, 32'h0000_0405, 32'hDEAD_BEEF, 0, t0);
        do_txn(0, 1'b0, 32'h0000_0405, 32'h0, 0, t0);
        chk("load_deadbeef_shadow", shadow[0][13'h405], 32'hDEAD_BEEF);
        do_txn(0, 1'b0, 32'h0000_2000, 32'h0, 0, t0);
        do_txn(0, 1'b1, 32'hFFFF_0405, 32'h1234_5678, 1, t0);
        do_txn(0, 1'b0, 32'h0000_0405, 32'h0, 5, t0);

        // Back-to-back stores with respReady high: one every three cycles.
        do_txn(0, 1'b1, 32'h0000_0010, 32'hA5A5_0001, 0, t0);
        do_txn(0, 1'b1, 32'h0000_0011, 32'hA5A5_0002, 0, t1);
        chk("store_throughput", 32'(t1 - t0), 32'd30);

        // Reset while a load is in ACCESS.
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 32'h0000_0405;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        chk("abort_in_access", 32'(resp_valid[0]), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_resp_valid", 32'(resp_valid[0]), 32'd0);
        chk("abort_mem_rw", 32'(mem_rw[0]), 32'd0);
        chk("abort_req_ready", 32'(req_ready[0]), 32'd1);
        chk("abort_mem_addr", mem_addr[0], 32'd0);
        chk("abort_resp_data", resp_data[0], 32'd0);
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid[0]) cnt++;
        end
        chk("abort_no_resp", 32'(cnt), 32'd0);
        do_txn(0, 1'b0, 32'h0000_0405, 32'h0, 0, t0);

        // Per-chip round trip at READ_LAT = 1 and 15.
        for (int s = 1; s < NDUT; s++) begin
            for (int chip = 0; chip < 8; chip++) begin
                a = {19'd0, 3'(chip), 10'($urandom)};
                d = $urandom;
                do_txn(s, 1'b1, a, d, $urandom_range(0, 2), t0);
                do_txn(s, 1'b0, a, 32'h0, $urandom_range(0, 2), t0);
            end
        end

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
